lcd1602_ctrl: RTL and testbench
===============================

LCD1602_CTRL -- requirements
Module: lcd1602_ctrl

Interface
REQ-001 Parameter PWRUP_TICKS, default 20, ticks waited after reset before the first command.
REQ-002 Parameter CLEAR_WAIT_TICKS, default 2, extra idle ticks after the clear command (0x01).
REQ-003 clk_48M  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 lcd_tick  input  1  one-clk_48M-cycle pulse from the upstream divider, period >= 1 ms; the only pacing source.
REQ-006 wr_en  input  1  host character-write strobe.
REQ-007 wr_addr  input  5  character index: 0-15 row 0, 16-31 row 1.
REQ-008 wr_data  input  8  ASCII code.
REQ-009 lcd_rs  output  1  register select: 0 = command, 1 = data.
REQ-010 lcd_rw  output  1  held constant 0 (write only).
REQ-011 lcd_en  output  1  LCD enable strobe.
REQ-012 lcd_data  output  8  LCD data bus.
REQ-013 init_done  output  1  high once the init sequence completes; stays high until reset.
REQ-014 frame_done  output  1  one-cycle pulse after character 31 is transferred.

Function
REQ-015 All LCD outputs SHALL be registered and change only on the clk_48M edge that samples lcd_tick=1; no lcd_tick means state and outputs hold.
REQ-016 Each byte transfer SHALL take 2 ticks: tick A drives lcd_rs and lcd_data with lcd_en=1; tick B drives lcd_en=0 while rs/data hold. rs/data SHALL not change while lcd_en=1.
REQ-017 FSM states SHALL be PWRUP, INIT, CLR_WAIT, ADDR0, ROW0, ADDR1, ROW1, IDLE.
REQ-018 PWRUP: count PWRUP_TICKS ticks, then go to INIT.
REQ-019 INIT: send commands 0x38, 0x0C, 0x06, 0x01 in order, then go to CLR_WAIT.
REQ-020 CLR_WAIT: wait CLR_WAIT_TICKS ticks, assert init_done, then go to ADDR0.
REQ-021 ADDR0: send 0x80, then go to ROW0. ROW0: send chars 0-15. ADDR1: send 0xC0. ROW1: send chars 16-31.
REQ-022 On completing ROW1, frame_done SHALL pulse for exactly one clk_48M cycle and the FSM SHALL go to IDLE.
REQ-023 One frame SHALL be 34 transfers = 68 ticks.
REQ-024 The character buffer SHALL hold 32 x 8 bits and write on the clock where wr_en=1; writes are always accepted, with no backpressure.
REQ-025 A character SHALL be sampled on its tick A; a write to an already-sent index SHALL appear in the next frame.
REQ-026 A write in the same cycle as that index's tick A SHALL drive the old value.
REQ-027 Writes SHALL be accepted in every state, including PWRUP.
REQ-028 Without LCD1602_DIRTY_EN, IDLE SHALL go to ADDR0 on the next tick (continuous refresh).

Reset
REQ-029 rst=0 SHALL immediately force lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0x00, init_done=0, frame_done=0, state PWRUP, all counters 0, every buffer entry 0x20, and dirty flag 0.
REQ-030 Reset asserted mid-transfer SHALL abort it; after release the full power-up and init sequence restarts.

Configuration
REQ-031 With LCD1602_DIRTY_EN defined, a dirty flag SHALL be set by wr_en and cleared on entry to ADDR0.
REQ-032 With LCD1602_DIRTY_EN defined, IDLE SHALL move to ADDR0 only on a tick where the dirty flag is 1.
REQ-033 With LCD1602_DIRTY_EN defined, a write during a frame SHALL cause one further frame.
REQ-034 With LCD1602_DIRTY_EN defined, the first frame after init SHALL always run.
REQ-035 Without LCD1602_DIRTY_EN defined, behaviour SHALL be REQ-028 and no dirty flag SHALL exist.

Structure
REQ-036 Package lcd1602_pkg SHALL hold the FSM state enum and the command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0, blank 0x20).
REQ-037 Sub-module lcd1602_char_ram SHALL implement the 32x8 buffer with one write port and one asynchronous read port.

Verification
REQ-038 Release reset, tick every 10 clks -> 20 ticks with lcd_en=0, then rs=0 bytes 0x38, 0x0C, 0x06, 0x01, 2 idle ticks, init_done=1, then 0x80.
REQ-039 Write addr0=0x48 and addr17=0x69 before the frame -> first data after 0x80 is 0x48; second data after 0xC0 is 0x69; other bytes are 0x20.
REQ-040 Count ticks from the 0x80 tick A -> frame_done pulses 1 cycle, 68 ticks later; the next 0x80 follows on the next tick when the macro is off.
REQ-041 Write addr5=0x41 at the tick A of char 5 -> old byte sent; 0x41 appears in the next frame.
REQ-042 Assert rst during ROW1 -> all outputs 0 at once; after release, PWRUP restarts and all chars read 0x20.
REQ-043 With LCD1602_DIRTY_EN, after the first frame -> no lcd_en for 100 ticks; single write -> ADDR0 on the next tick, exactly one frame.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared types and HD44780 command bytes for the 16x2 LCD refresh controller.
package lcd1602_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_CLR_WAIT,
      ST_ADDR0,
      ST_ROW0,
      ST_ADDR1,
      ST_ROW1,
      ST_IDLE
   } lcd_state_e;

   localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
   localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_ROW0       = 8'h80;
   localparam logic [7:0] CMD_ROW1       = 8'hC0;
   localparam logic [7:0] CHAR_BLANK     = 8'h20;

   localparam int NUM_CHARS = 32;

   // Init command issued for each step of the four-command power-on sequence.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = CMD_FUNC_SET;
         2'd1:    cmd = CMD_DISP_ON;
         2'd2:    cmd = CMD_ENTRY_MODE;
         default: cmd = CMD_CLEAR;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd1602_char_ram.sv
// 32x8 character buffer: one write port, asynchronous read, resets to blanks.
module lcd1602_char_ram
   import lcd1602_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       wr_en_i,
   input  logic [4:0] wr_addr_i,
   input  logic [7:0] wr_data_i,
   input  logic [4:0] rd_addr_i,
   output logic [7:0] rd_data_o
);

   logic [7:0] mem_q [NUM_CHARS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_CHARS; i++) begin
            mem_q[i] <= CHAR_BLANK;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read sees the pre-write contents in the cycle of a write to the same index.
   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lcd1602_ctrl.sv
// 16x2 LCD controller: power-up wait, init sequence, then frames of 34 byte transfers.
// Define LCD1602_DIRTY_EN to refresh only after host writes instead of continuously.
module lcd1602_ctrl
   import lcd1602_pkg::*;
#(
   parameter int PWRUP_TICKS      = 20,
   parameter int CLEAR_WAIT_TICKS = 2
) (
   input  logic       clk_48M,
   input  logic       rst,
   input  logic       lcd_tick,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       frame_done
);

   lcd_state_e  state_q;
   logic [15:0] cnt_q;
   logic        phase_b_q;
   logic        lcd_rs_q;
   logic        lcd_en_q;
   logic [7:0]  lcd_data_q;
   logic        init_done_q;
   logic        frame_done_q;

   logic [4:0]  rd_addr_d;
   logic [7:0]  rd_data_d;
   logic        xfer_rs_d;
   logic [7:0]  xfer_byte_d;
   logic        pwrup_done_d;
   logic        clr_done_d;
   logic        go_d;

   lcd1602_char_ram u_char_ram (
      .clk_i     (clk_48M),
      .rst_ni    (rst),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (rd_addr_d),
      .rd_data_o (rd_data_d)
   );

   assign rd_addr_d    = {state_q == ST_ROW1, cnt_q[3:0]};
   assign pwrup_done_d = (int'(cnt_q) + 1) >= PWRUP_TICKS;
   assign clr_done_d   = (int'(cnt_q) + 1) >= CLEAR_WAIT_TICKS;

   // Byte and register select presented on the tick A of the current state.
   always_comb begin
      xfer_rs_d   = 1'b0;
      xfer_byte_d = 8'h00;
      case (state_q)
         ST_INIT:            xfer_byte_d = init_cmd(cnt_q[1:0]);
         ST_ADDR0, ST_IDLE:  xfer_byte_d = CMD_ROW0;
         ST_ADDR1:           xfer_byte_d = CMD_ROW1;
         ST_ROW0, ST_ROW1: begin
            xfer_rs_d   = 1'b1;
            xfer_byte_d = rd_data_d;
         end
         default: ;
      endcase
   end

`ifdef LCD1602_DIRTY_EN
   logic dirty_q;
   logic enter_addr0_d;

   assign enter_addr0_d = lcd_tick && !phase_b_q &&
                          ((state_q == ST_CLR_WAIT && clr_done_d) ||
                           (state_q == ST_IDLE && dirty_q));

   // A write landing on the same edge as the ADDR0 entry keeps the flag set.
   always_ff @(posedge clk_48M or negedge rst) begin
      if (!rst) begin
         dirty_q <= 1'b0;
      end else if (wr_en) begin
         dirty_q <= 1'b1;
      end else if (enter_addr0_d) begin
         dirty_q <= 1'b0;
      end
   end

   assign go_d = dirty_q;
`else
   assign go_d = 1'b1;
`endif

   always_ff @(posedge clk_48M or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_PWRUP;
         cnt_q        <= '0;
         phase_b_q    <= 1'b0;
         lcd_rs_q     <= 1'b0;
         lcd_en_q     <= 1'b0;
         lcd_data_q   <= 8'h00;
         init_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (lcd_tick) begin
            if (phase_b_q) begin
               // Tick B: drop the strobe, rs/data hold, then advance.
               lcd_en_q  <= 1'b0;
               phase_b_q <= 1'b0;
               case (state_q)
                  ST_INIT: begin
                     if (cnt_q == 16'd3) begin
                        state_q <= ST_CLR_WAIT;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_q + 16'd1;
                     end
                  end
                  ST_ADDR0: begin
                     state_q <= ST_ROW0;
                     cnt_q   <= '0;
                  end
                  ST_ROW0: begin
                     if (cnt_q == 16'd15) begin
                        state_q <= ST_ADDR1;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_q + 16'd1;
                     end
                  end
                  ST_ADDR1: begin
                     state_q <= ST_ROW1;
                     cnt_q   <= '0;
                  end
                  ST_ROW1: begin
                     if (cnt_q == 16'd15) begin
                        state_q      <= ST_IDLE;
                        cnt_q        <= '0;
                        frame_done_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + 16'd1;
                     end
                  end
                  default: ;
               endcase
            end else begin
               case (state_q)
                  ST_PWRUP: begin
                     if (pwrup_done_d) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_q + 16'd1;
                     end
                  end
                  ST_CLR_WAIT: begin
                     if (clr_done_d) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_ADDR0;
                        cnt_q       <= '0;
                     end else begin
                        cnt_q <= cnt_q + 16'd1;
                     end
                  end
                  ST_IDLE: begin
                     // Leaving IDLE issues the 0x80 tick A on the same tick.
                     if (go_d) begin
                        state_q    <= ST_ADDR0;
                        lcd_en_q   <= 1'b1;
                        lcd_rs_q   <= xfer_rs_d;
                        lcd_data_q <= xfer_byte_d;
                        phase_b_q  <= 1'b1;
                     end
                  end
                  default: begin
                     lcd_en_q   <= 1'b1;
                     lcd_rs_q   <= xfer_rs_d;
                     lcd_data_q <= xfer_byte_d;
                     phase_b_q  <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

   assign lcd_rs     = lcd_rs_q;
   assign lcd_rw     = 1'b0;
   assign lcd_en     = lcd_en_q;
   assign lcd_data   = lcd_data_q;
   assign init_done  = init_done_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// Bench for lcd1602_ctrl: per-tick expected output vectors plus reset and refresh sequences.
// Exercises the LCD1602_DIRTY_EN refresh policy when that macro is defined.
module tb_lcd1602_ctrl;

   logic       clk_48M = 1'b0;
   logic       rst = 1'b0;
   logic       lcd_tick = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       lcd_rs, lcd_rw, lcd_en;
   logic [7:0] lcd_data;
   logic       init_done, frame_done;

   lcd1602_ctrl #(.PWRUP_TICKS(20), .CLEAR_WAIT_TICKS(2)) dut (
      .clk_48M    (clk_48M),
      .rst        (rst),
      .lcd_tick   (lcd_tick),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en),
      .lcd_data   (lcd_data),
      .init_done  (init_done),
      .frame_done (frame_done)
   );

   always #5 clk_48M = ~clk_48M;

   typedef struct {
      logic       wr;
      logic [4:0] waddr;
      logic [7:0] wdata;
      logic       en;
      logic       rs;
      logic [7:0] data;
      logic       init;
      logic       fd;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] model[32];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {20'd0, lcd_rw, lcd_en, lcd_rs, lcd_data, init_done, frame_done};
   endfunction

   function automatic void push(input logic en, input logic rs, input logic [7:0] data,
                                input logic init, input logic fd);
      vec_t v;
      v.wr = 1'b0; v.waddr = '0; v.wdata = '0;
      v.en = en; v.rs = rs; v.data = data; v.init = init; v.fd = fd;
      vecs.push_back(v);
   endfunction

   function automatic void push_xfer(input logic rs, input logic [7:0] data,
                                     input logic init, input logic last);
      push(1'b1, rs, data, init, 1'b0);
      push(1'b0, rs, data, init, last);
   endfunction

   function automatic void push_init();
      for (int i = 0; i < 20; i++) push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      push_xfer(1'b0, 8'h38, 1'b0, 1'b0);
      push_xfer(1'b0, 8'h0C, 1'b0, 1'b0);
      push_xfer(1'b0, 8'h06, 1'b0, 1'b0);
      push_xfer(1'b0, 8'h01, 1'b0, 1'b0);
      push(1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
      push(1'b0, 1'b0, 8'h01, 1'b1, 1'b0);
   endfunction

   function automatic void push_frame();
      push_xfer(1'b0, 8'h80, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) push_xfer(1'b1, model[i], 1'b1, 1'b0);
      push_xfer(1'b0, 8'hC0, 1'b1, 1'b0);
      for (int i = 16; i < 32; i++) push_xfer(1'b1, model[i], 1'b1, i == 31);
   endfunction

   function automatic void set_wr(input int idx, input logic [4:0] a, input logic [7:0] d);
      vec_t v;
      v = vecs[idx];
      v.wr = 1'b1; v.waddr = a; v.wdata = d;
      vecs[idx] = v;
   endfunction

   // One tick per record (10 clocks apart); sample just after the tick edge and
   // again at the end of the quiet period to confirm outputs hold between ticks.
   task automatic run_vecs(input int n);
      for (int i = 0; i < n && i < vecs.size(); i++) begin
         @(negedge clk_48M);
         lcd_tick = 1'b1;
         wr_en    = vecs[i].wr;
         wr_addr  = vecs[i].waddr;
         wr_data  = vecs[i].wdata;
         @(negedge clk_48M);
         lcd_tick = 1'b0;
         wr_en    = 1'b0;
         check($sformatf("vec%0d", i), outs(),
               {20'd0, 1'b0, vecs[i].en, vecs[i].rs, vecs[i].data, vecs[i].init, vecs[i].fd});
         @(negedge clk_48M);
         if (vecs[i].fd) check($sformatf("fd_width%0d", i), {31'd0, frame_done}, 32'd0);
         repeat (7) @(negedge clk_48M);
         check($sformatf("hold%0d", i), outs(),
               {20'd0, 1'b0, vecs[i].en, vecs[i].rs, vecs[i].data, vecs[i].init, 1'b0});
      end
   endtask

   task automatic host_write(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk_48M);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk_48M);
      wr_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 8'h20;

      repeat (3) @(negedge clk_48M);
      check("reset_state", outs(), 32'd0);
      rst = 1'b1;

      // Power-up, init, frame 1 (with PWRUP writes), frame 2 (with mid-frame writes).
      push_init();
      set_wr(3, 5'd0, 8'h48);
      set_wr(7, 5'd17, 8'h69);
      model[0]  = 8'h48;
      model[17] = 8'h69;
      push_frame();
      set_wr(42, 5'd5, 8'h41);
      set_wr(70, 5'd0, 8'h5A);
      model[5] = 8'h41;
      model[0] = 8'h5A;
      push_frame();
      run_vecs(vecs.size());

`ifdef LCD1602_DIRTY_EN
      vecs.delete();
      for (int i = 0; i < 100; i++) push(1'b0, 1'b1, model[31], 1'b1, 1'b0);
      run_vecs(vecs.size());
      host_write(5'd31, 8'h7E);
      model[31] = 8'h7E;
      vecs.delete();
      push_frame();
      for (int i = 0; i < 20; i++) push(1'b0, 1'b1, model[31], 1'b1, 1'b0);
      run_vecs(vecs.size());
      host_write(5'd10, 8'h33);
      model[10] = 8'h33;
`endif

      // Stop on a ROW1 tick A (en=1) and hit reset between clock edges.
      vecs.delete();
      push_frame();
      run_vecs(41);
      #2 rst = 1'b0;
      #1 check("async_reset", outs(), 32'd0);
      @(negedge clk_48M);
      lcd_tick = 1'b1;
      @(negedge clk_48M);
      lcd_tick = 1'b0;
      check("reset_hold", outs(), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 32; i++) model[i] = 8'h20;
      vecs.delete();
      push_init();
      push_frame();
      run_vecs(vecs.size());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
